// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, limits and widths for the MEM-stage stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WAIT_CNT_W  = 8;
  localparam int unsigned STALL_CNT_W = 32;
  localparam int unsigned MISS_CNT_W  = 16;

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  // Request latched at miss detection and held on the memory port until ack.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
  } mem_req_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over enable.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage miss/store stall controller with bounded memory handshake.
// Optional performance counters enabled by defining STALL_PERF_CNT_EN.
module mem_stall_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_rd_i,
  input  logic                   mem_wr_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   hit_i,
  input  logic                   mem_ack_i,
  output logic                   halt_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic                   fill_o,
  output logic                   timeout_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic [MISS_CNT_W-1:0]  miss_cnt_o
);

  state_e                r_state;
  state_e                w_state_nxt;
  mem_req_t              r_req;
  logic                  r_mem_req;
  logic                  r_fill;
  logic                  r_timeout;
  logic                  w_miss;
  logic                  w_halt;
  logic                  w_start;
  logic                  w_timeout_set;
  logic                  w_wait_en;
  logic [WAIT_CNT_W-1:0] w_wait_cnt;

  // A store always needs the memory port; a load only when the cache misses.
  assign w_miss    = ~rst_i & ((mem_rd_i & ~hit_i) | mem_wr_i);
  assign w_wait_en = (r_state == REQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait count reaches the limit on the edge closing the last allowed REQ cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_halt        = 1'b0;
    w_start       = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          w_halt      = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_halt = 1'b1;
        if (mem_ack_i) begin
          w_state_nxt = r_req.we ? IDLE : FILL;
        end else if (w_wait_cnt == (TIMEOUT_LIMIT - 8'd1)) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      FILL: begin
        w_halt      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req     <= '0;
      r_mem_req <= 1'b0;
      r_fill    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_mem_req <= (w_state_nxt == REQ);
      r_fill    <= (w_state_nxt == FILL);
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      if (w_start) begin
        r_req.we   <= mem_wr_i;
        r_req.addr <= addr_i;
      end
    end
  end

  sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (w_start),
    .i_en  (w_wait_en),
    .o_cnt (w_wait_cnt)
  );

`ifdef STALL_PERF_CNT_EN
  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (1'b0),
    .i_en  (w_halt),
    .o_cnt (stall_cnt_o)
  );

  sat_counter #(.W(MISS_CNT_W)) u_miss_cnt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (1'b0),
    .i_en  (w_start),
    .o_cnt (miss_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign miss_cnt_o  = '0;
`endif

  assign halt_o     = w_halt;
  assign mem_req_o  = r_mem_req;
  assign mem_we_o   = r_req.we;
  assign mem_addr_o = r_req.addr;
  assign fill_o     = r_fill;
  assign timeout_o  = r_timeout;

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  rising-edge clock.
REQ-002 SHALL have: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: mem_rd_i  in  1  MEM-stage load (EX/MEM M bit 1).
REQ-004 SHALL have: mem_wr_i  in  1  MEM-stage store (EX/MEM M bit 0).
REQ-005 SHALL have: addr_i  in  32  MEM-stage address (EX/MEM addr).
REQ-006 SHALL have: hit_i  in  1  data-cache hit for addr_i, same cycle.
REQ-007 SHALL have: mem_ack_i  in  1  backing memory acknowledge.
REQ-008 SHALL have: halt_o  out  1  freeze to PC, IF/ID, ID/EX, EX/MEM, MEM/WB halt inputs.
REQ-009 SHALL have: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32  memory request, held until ack.
REQ-010 SHALL have: fill_o  out  1  cache refill write strobe.
REQ-011 SHALL have: timeout_o  out  1  sticky: ack not received in time.
REQ-012 SHALL have: stall_cnt_o  out  32; miss_cnt_o  out  16  performance counters.

Function
REQ-013 SHALL implement FSM IDLE, REQ, FILL.
REQ-014 IDLE: (mem_rd_i & ~hit_i) or mem_wr_i SHALL latch addr_i and the write flag, then go to REQ; otherwise stay in IDLE.
REQ-015 mem_rd_i and mem_wr_i both high SHALL be treated as a write.
REQ-016 halt_o SHALL be combinational: 1 in IDLE on the REQ-014 condition, 1 in REQ and FILL, else 0.
REQ-017 REQ: mem_req_o=1; mem_addr_o and mem_we_o stable at the latched values until mem_ack_i is sampled high.
REQ-018 REQ with ack: a read SHALL go to FILL; a write SHALL go to IDLE.
REQ-019 FILL SHALL last exactly 1 cycle with fill_o=1, then go to IDLE. The cache then hits, so halt_o drops.
REQ-020 Read-miss halt SHALL be 1 (detect) + N (REQ cycles through the ack cycle) + 1 (FILL) cycles. Write halt SHALL be 1 + N cycles.
REQ-021 mem_ack_i SHALL be ignored outside REQ.
REQ-022 An 8-bit wait counter SHALL clear on entering REQ and increment each REQ cycle.
REQ-023 At count 255 without ack: set timeout_o, drop mem_req_o, return to IDLE. timeout_o clears only on reset.
REQ-024 Counters SHALL saturate at all-ones; they never wrap.

Reset
REQ-025 When rst_i is sampled high (including mid-REQ/FILL), all outputs SHALL be 0 and the FSM in IDLE by the next edge.
REQ-026 Reset values: mem_addr_o=0, wait counter=0, timeout_o=0, stall_cnt_o=0, miss_cnt_o=0.
REQ-027 An in-flight request SHALL be abandoned with no fill_o pulse.

Configuration
REQ-028 Macro STALL_PERF_CNT_EN.
- Defined: stall_cnt_o increments each cycle halt_o=1; miss_cnt_o increments on each IDLE->REQ transition.
- Undefined: both ports exist and SHALL be constant 0, with no counter registers.

Structure
REQ-029 Shared package/header pipe_ctrl_pkg SHALL hold the state encodings (IDLE=2'd0, REQ=2'd1, FILL=2'd2), TIMEOUT_LIMIT=8'd255, and the counter widths.
REQ-030 One sub-module, sat_counter (parameterised width, clear/enable, saturating), SHALL be used for the wait counter and both perf counters.

Verification
REQ-031 Load hit, addr 0x100 -> halt_o=0, mem_req_o never asserted.
REQ-032 Load miss 0x200, ack on 3rd REQ cycle:
- mem_addr_o=0x200, mem_we_o=0 throughout.
- fill_o pulses once; halt_o high 5 cycles.
- miss_cnt_o=1, stall_cnt_o=5 (STALL_PERF_CNT_EN).
REQ-033 Store to 0x300, ack after 1 cycle -> mem_we_o=1, halt_o high 2 cycles, fill_o never asserted.
REQ-034 Load miss, ack never asserted -> after 255 REQ cycles timeout_o=1, mem_req_o=0, FSM in IDLE; timeout_o stays 1.
REQ-035 rst_i high during REQ with ack pending -> next cycle halt_o=0, mem_req_o=0, no fill_o; a later ack is ignored.
REQ-036 STALL_PERF_CNT_EN undefined, same stimulus as REQ-032 -> stall_cnt_o=miss_cnt_o=0, identical handshake timing.
